// File: rtl/gpio_in_conditioner_pkg.sv
// Shared constants and the parity helper for the GPIO input conditioner.
// Also used by the AHB GPIO parity checker and the bench scoreboard.
package gpio_in_conditioner_pkg;

   localparam int GPIO_DATA_W          = 16;
   localparam int GPIO_DEBOUNCE_CYCLES = 4;
   localparam int GPIO_GLITCH_W        = 8;
   localparam int GPIO_PARITY_MAX_W    = 64;

   // odd=1 yields a parity bit that makes the total count of ones odd
   function automatic logic gpio_parity(
      input logic [GPIO_PARITY_MAX_W-1:0] data,
      input logic                         odd
   );
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Pin-side and GPIOIN-side signal bundle of the GPIO input conditioner.
// master drives pins and controls; slave is the conditioner itself.
interface gpio_in_conditioner_if #(
   parameter int DATA_W   = 16,
   parameter int GLITCH_W = 8
);

   logic [DATA_W-1:0]   pin_in;
   logic                parity_sel;
   logic                inject_err;
   logic                glitch_clr;
   logic [DATA_W:0]     gpio_in;
   logic                change_pulse;
   logic [GLITCH_W-1:0] glitch_cnt;

   modport master (
      output pin_in,
      output parity_sel,
      output inject_err,
      output glitch_clr,
      input  gpio_in,
      input  change_pulse,
      input  glitch_cnt
   );

   modport slave (
      input  pin_in,
      input  parity_sel,
      input  inject_err,
      input  glitch_clr,
      output gpio_in,
      output change_pulse,
      output glitch_cnt
   );

endinterface

// File: rtl/gpio_in_conditioner_debounce_bit.sv
// One pin: 2-flop synchroniser, run-length debounce counter, glitch flag.
// update and glitch are combinational views of the decision taken this edge.
module gpio_in_conditioner_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic stable,
   output logic update,
   output logic glitch
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;
   logic          differ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= pin;
         sync <= meta;
      end
   end

   assign differ = (sync != stable);
   assign update = differ && (cnt == CNT_LAST);
   // a partial run that falls back to the stable level is a rejected glitch
   assign glitch = !differ && (cnt != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (!differ) begin
         cnt <= '0;
      end else if (update) begin
         stable <= sync;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions raw GPIO pins into a debounced word plus parity for GPIOIN.
// Also reports stable changes and a saturating count of rejected glitches.
module gpio_in_conditioner
   import gpio_in_conditioner_pkg::*;
#(
   parameter int DATA_W          = GPIO_DATA_W,
   parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
   parameter int GLITCH_W        = GPIO_GLITCH_W
) (
   input logic                  clk,
   input logic                  reset,
   gpio_in_conditioner_if.slave bus
);

   localparam int POP_W = $clog2(DATA_W + 1);
   localparam int SUM_W = GLITCH_W + POP_W;
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   logic [DATA_W-1:0]   stable_data;
   logic [DATA_W-1:0]   upd;
   logic [DATA_W-1:0]   glitch;
   logic [SUM_W-1:0]    glitch_sum;
   logic [GLITCH_W-1:0] glitch_next;
   logic [GLITCH_W-1:0] glitch_cnt;
   logic                change_pulse;
   logic                parity;

   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      gpio_in_conditioner_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .pin   (bus.pin_in[i]),
         .stable(stable_data[i]),
         .update(upd[i]),
         .glitch(glitch[i])
      );
   end

   // sum is wide enough that every bit glitching at once cannot wrap
   always_comb begin
      glitch_sum = SUM_W'(glitch_cnt);
      for (int i = 0; i < DATA_W; i++) begin
         glitch_sum = glitch_sum + SUM_W'(glitch[i]);
      end
      glitch_next = glitch_sum[GLITCH_W-1:0];
      if (glitch_sum > SUM_W'(GLITCH_MAX)) begin
         glitch_next = GLITCH_MAX;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         change_pulse <= 1'b0;
         glitch_cnt   <= '0;
      end else begin
         change_pulse <= |upd;
         glitch_cnt   <= bus.glitch_clr ? '0 : glitch_next;
      end
   end

   // kept combinational so a per-cycle parity_sel change lands with no skew
   assign parity = gpio_parity(GPIO_PARITY_MAX_W'(stable_data),
                               bus.parity_sel) ^ bus.inject_err;

   assign bus.gpio_in      = {parity, stable_data};
   assign bus.change_pulse = change_pulse;
   assign bus.glitch_cnt   = glitch_cnt;

endmodule
